// File: rtl/rob_multi_pkg.sv
// Shared definitions for the multi-lane reorder buffer.
// Holds the default geometry and the packed views of one ROB entry and
// of one dispatch / retire lane. These are kept as documentation of the
// entry layout and as defaults for the top-level parameters.
package rob_multi_pkg;

    localparam int ROB_DEPTH  = 32;
    localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
    localparam int ROB_ARCH_W = 5;
    localparam int ROB_PHYS_W = 6;

    // One ROB slot at the default geometry.
    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic [ROB_ARCH_W-1:0] arch;
        logic [ROB_PHYS_W-1:0] phys;
        logic [ROB_PHYS_W-1:0] old_phys;
        logic                  has_dest;
    } rob_entry_t;

    // Fields carried by one dispatch lane.
    typedef struct packed {
        logic [ROB_ARCH_W-1:0] arch;
        logic [ROB_PHYS_W-1:0] phys;
        logic [ROB_PHYS_W-1:0] old_phys;
        logic                  has_dest;
    } rob_disp_lane_t;

    // Fields presented by one retire lane.
    typedef struct packed {
        logic [ROB_ARCH_W-1:0] arch;
        logic [ROB_PHYS_W-1:0] phys;
        logic [ROB_PHYS_W-1:0] old_phys;
        logic                  has_dest;
    } rob_ret_lane_t;

endpackage

// File: rtl/rob_multi_retire_sel.sv
// Retire lane selector: prefix scan over head-relative "ready to retire"
// bits. A lane retires only if it and every older lane are ready, so the
// output mask is always contiguous from lane 0.
//   rdy_i       : per head-relative position, entry valid and complete
//   ret_valid_o : contiguous retire mask
//   ret_cnt_o   : number of set bits in ret_valid_o
module rob_multi_retire_sel #(
    parameter int RETIRE_W = 2,
    parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
    input  logic [RETIRE_W-1:0] rdy_i,
    output logic [RETIRE_W-1:0] ret_valid_o,
    output logic [CNT_W-1:0]    ret_cnt_o
);

    logic run;

    always_comb begin
        run         = 1'b1;
        ret_valid_o = '0;
        ret_cnt_o   = '0;
        for (int j = 0; j < RETIRE_W; j++) begin
            run            = run & rdy_i[j];
            ret_valid_o[j] = run;
            ret_cnt_o      = ret_cnt_o + CNT_W'(run);
        end
    end

endmodule

// File: rtl/rob_multi.sv
// N-wide reorder buffer with multi-lane dispatch, completion and retire,
// plus branch-mispredict squash of entries younger than a given slot.
// Ports:
//   clock, reset            : clock, asynchronous active-low reset
//   disp_*                  : dispatch group (lanes contiguous from lane 0)
//   disp_accept / disp_idx  : group accepted this cycle / slot per lane
//   free_slots, empty       : occupancy view from registered state
//   cmpl_valid / cmpl_idx   : completion strobes per CDB lane
//   squash_valid/squash_idx : keep squash_idx, kill everything younger
//   ret_*                   : retiring entries, contiguous from lane 0
// Handshake: a dispatch group is taken at the clock edge only when
// disp_accept is high; there is no back-pressure on completion or retire,
// ret_valid lanes are consumed unconditionally at the next edge.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int DISPATCH_W = 2,
    parameter int COMPLETE_W = 2,
    parameter int RETIRE_W   = 2,
    parameter int PHYS_W     = ROB_PHYS_W,
    parameter int ARCH_W     = ROB_ARCH_W,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int PTR_W     = IDX_W + 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [DISPATCH_W-1:0]                 disp_valid,
    input  logic [DISPATCH_W-1:0][ARCH_W-1:0]     disp_arch,
    input  logic [DISPATCH_W-1:0][PHYS_W-1:0]     disp_phys,
    input  logic [DISPATCH_W-1:0][PHYS_W-1:0]     disp_old_phys,
    input  logic [DISPATCH_W-1:0]                 disp_has_dest,
    output logic                                  disp_accept,
    output logic [DISPATCH_W-1:0][IDX_W-1:0]      disp_idx,
    output logic [PTR_W-1:0]                      free_slots,
    input  logic [COMPLETE_W-1:0]                 cmpl_valid,
    input  logic [COMPLETE_W-1:0][IDX_W-1:0]      cmpl_idx,
    input  logic                                  squash_valid,
    input  logic [IDX_W-1:0]                      squash_idx,
    output logic [RETIRE_W-1:0]                   ret_valid,
    output logic [RETIRE_W-1:0][ARCH_W-1:0]       ret_arch,
    output logic [RETIRE_W-1:0][PHYS_W-1:0]       ret_phys,
    output logic [RETIRE_W-1:0][PHYS_W-1:0]       ret_old_phys,
    output logic [RETIRE_W-1:0]                   ret_has_dest,
    output logic                                  empty
);

    localparam int CNT_W = $clog2(RETIRE_W + 1);

    // Pointers carry an extra wrap bit so full and empty are distinct.
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] count, disp_n;
    logic [IDX_W-1:0] head_idx, tail_idx, sq_off;

    logic [DEPTH-1:0] valid_q, valid_d, cmpl_q, cmpl_d;
    logic [ARCH_W-1:0] arch_q [DEPTH];
    logic [PHYS_W-1:0] phys_q [DEPTH];
    logic [PHYS_W-1:0] old_q  [DEPTH];
    logic [DEPTH-1:0]  dest_q;

    logic [RETIRE_W-1:0]            ret_rdy;
    logic [RETIRE_W-1:0][IDX_W-1:0] ret_slot;
    logic [CNT_W-1:0]               ret_cnt;

    assign head_idx   = head_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign count      = tail_q - head_q;
    assign free_slots = PTR_W'(DEPTH) - count;
    assign empty      = (count == '0);
    // Age of the squashing branch relative to head; everything older than
    // or equal to it survives.
    assign sq_off     = squash_idx - head_idx;

    always_comb begin
        disp_n = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            disp_n = disp_n + PTR_W'(disp_valid[i]);
        end
    end

    assign disp_accept = (disp_n <= free_slots) && !squash_valid;

    always_comb begin
        disp_idx = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            disp_idx[i] = tail_idx + IDX_W'(i);
        end
    end

    // Retire candidates. During a squash, only the branch and older
    // entries may retire, so head never passes the retracted tail.
    always_comb begin
        ret_slot = '0;
        ret_rdy  = '0;
        for (int j = 0; j < RETIRE_W; j++) begin
            ret_slot[j] = head_idx + IDX_W'(j);
            ret_rdy[j]  = valid_q[ret_slot[j]] && cmpl_q[ret_slot[j]] &&
                          (PTR_W'(j) < count) &&
                          (!squash_valid || (IDX_W'(j) <= sq_off));
        end
    end

    rob_multi_retire_sel #(
        .RETIRE_W (RETIRE_W),
        .CNT_W    (CNT_W)
    ) u_retire_sel (
        .rdy_i       (ret_rdy),
        .ret_valid_o (ret_valid),
        .ret_cnt_o   (ret_cnt)
    );

    always_comb begin
        ret_arch     = '0;
        ret_phys     = '0;
        ret_old_phys = '0;
        ret_has_dest = '0;
        for (int j = 0; j < RETIRE_W; j++) begin
            ret_arch[j]     = arch_q[ret_slot[j]];
            ret_phys[j]     = phys_q[ret_slot[j]];
            ret_old_phys[j] = old_q[ret_slot[j]];
            ret_has_dest[j] = dest_q[ret_slot[j]];
        end
    end

    // Next-state for the per-slot flags. Order matters: completion marks
    // first, then retire and squash clear, so a completion landing on a
    // killed or retiring slot leaves nothing behind.
    always_comb begin
        valid_d = valid_q;
        cmpl_d  = cmpl_q;
        for (int l = 0; l < COMPLETE_W; l++) begin
            if (cmpl_valid[l] && valid_q[cmpl_idx[l]]) begin
                cmpl_d[cmpl_idx[l]] = 1'b1;
            end
        end
        for (int j = 0; j < RETIRE_W; j++) begin
            if (ret_valid[j]) begin
                valid_d[ret_slot[j]] = 1'b0;
                cmpl_d[ret_slot[j]]  = 1'b0;
            end
        end
        if (squash_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((IDX_W'(k) - head_idx) > sq_off) begin
                    valid_d[k] = 1'b0;
                    cmpl_d[k]  = 1'b0;
                end
            end
        end
        if (disp_accept) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (disp_valid[i]) begin
                    valid_d[disp_idx[i]] = 1'b1;
                    cmpl_d[disp_idx[i]]  = 1'b0;
                end
            end
        end

        head_d = head_q + PTR_W'(ret_cnt);
        if (squash_valid) begin
            tail_d = head_q + PTR_W'(sq_off) + PTR_W'(1);
        end else if (disp_accept) begin
            tail_d = tail_q + disp_n;
        end else begin
            tail_d = tail_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            cmpl_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            cmpl_q  <= cmpl_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        if (disp_accept) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (disp_valid[i]) begin
                    arch_q[disp_idx[i]] <= disp_arch[i];
                    phys_q[disp_idx[i]] <= disp_phys[i];
                    old_q[disp_idx[i]]  <= disp_old_phys[i];
                    dest_q[disp_idx[i]] <= disp_has_dest[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
module tb_rob_multi;

    localparam int DEPTH = 32;
    localparam int DW    = 2;
    localparam int CW    = 2;
    localparam int RW    = 2;
    localparam int PW    = 6;
    localparam int AW    = 5;
    localparam int IW    = 5;

    logic                 clock;
    logic                 reset;
    logic [DW-1:0]        disp_valid;
    logic [DW-1:0][AW-1:0] disp_arch;
    logic [DW-1:0][PW-1:0] disp_phys;
    logic [DW-1:0][PW-1:0] disp_old_phys;
    logic [DW-1:0]        disp_has_dest;
    logic                 disp_accept;
    logic [DW-1:0][IW-1:0] disp_idx;
    logic [IW:0]          free_slots;
    logic [CW-1:0]        cmpl_valid;
    logic [CW-1:0][IW-1:0] cmpl_idx;
    logic                 squash_valid;
    logic [IW-1:0]        squash_idx;
    logic [RW-1:0]        ret_valid;
    logic [RW-1:0][AW-1:0] ret_arch;
    logic [RW-1:0][PW-1:0] ret_phys;
    logic [RW-1:0][PW-1:0] ret_old_phys;
    logic [RW-1:0]        ret_has_dest;
    logic                 empty;

    rob_multi #(
        .DEPTH(DEPTH), .DISPATCH_W(DW), .COMPLETE_W(CW), .RETIRE_W(RW),
        .PHYS_W(PW), .ARCH_W(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_arch(disp_arch), .disp_phys(disp_phys),
        .disp_old_phys(disp_old_phys), .disp_has_dest(disp_has_dest),
        .disp_accept(disp_accept), .disp_idx(disp_idx), .free_slots(free_slots),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .squash_valid(squash_valid), .squash_idx(squash_idx),
        .ret_valid(ret_valid), .ret_arch(ret_arch), .ret_phys(ret_phys),
        .ret_old_phys(ret_old_phys), .ret_has_dest(ret_has_dest),
        .empty(empty)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Program-order list of live instructions, oldest first.
    typedef struct {
        int            slot;
        logic [AW-1:0] arch;
        logic [PW-1:0] phys;
        logic [PW-1:0] old;
        logic          dest;
        bit            done;
    } ent_t;

    ent_t mq[$];
    int   tail_slot;
    int   n_total;
    int   n_bad;
    int   n_disp;
    int   n_ret;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        tail_slot = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_in();
        disp_valid    = '0;
        disp_arch     = '0;
        disp_phys     = '0;
        disp_old_phys = '0;
        disp_has_dest = '0;
        cmpl_valid    = '0;
        cmpl_idx      = '0;
        squash_valid  = 1'b0;
        squash_idx    = '0;
    endtask

    task automatic set_disp(input int n);
        for (int i = 0; i < DW; i++) begin
            disp_valid[i]    = (i < n);
            disp_arch[i]     = AW'($urandom);
            disp_phys[i]     = PW'($urandom);
            disp_old_phys[i] = PW'($urandom);
            disp_has_dest[i] = 1'($urandom);
        end
    endtask

    // Complete the oldest (up to CW) not-yet-complete entries.
    task automatic cmpl_oldest();
        int m;
        m = 0;
        foreach (mq[e]) begin
            if (!mq[e].done && m < CW) begin
                cmpl_valid[m] = 1'b1;
                cmpl_idx[m]   = IW'(mq[e].slot);
                m++;
            end
        end
    endtask

    // One cycle: check combinational outputs against the model with the
    // current inputs, clock, then advance the model by the same inputs.
    task automatic step();
        int   n;
        int   k;
        int   sq_pos;
        bit   acc;
        ent_t e;
        #1;
        assert (disp_valid != 2'b10) else $error("non-contiguous dispatch");
        n = 0;
        for (int i = 0; i < DW; i++) n += int'(disp_valid[i]);
        sq_pos = -1;
        if (squash_valid) begin
            foreach (mq[x]) if (mq[x].slot == int'(squash_idx)) sq_pos = x;
            assert (sq_pos >= 0) else $error("squash outside occupied range");
        end
        acc = (n <= DEPTH - mq.size()) && !squash_valid;
        check_val("disp_accept", disp_accept, acc);
        for (int i = 0; i < DW; i++) check_val("disp_idx", disp_idx[i], (tail_slot + i) % DEPTH);
        check_val("free_slots", free_slots, DEPTH - mq.size());
        check_val("empty", empty, mq.size() == 0);
        k = 0;
        while (k < RW && k < mq.size() && mq[k].done && (sq_pos < 0 || k <= sq_pos)) k++;
        check_val("ret_valid", ret_valid, (1 << k) - 1);
        for (int j = 0; j < k; j++) begin
            check_val("ret_lane",
                      {ret_arch[j], ret_phys[j], ret_old_phys[j], ret_has_dest[j]},
                      {mq[j].arch, mq[j].phys, mq[j].old, mq[j].dest});
        end
        @(posedge clock);
        for (int l = 0; l < CW; l++) begin
            if (cmpl_valid[l]) foreach (mq[x]) if (mq[x].slot == int'(cmpl_idx[l])) mq[x].done = 1'b1;
        end
        if (sq_pos >= 0) begin
            while (mq.size() > sq_pos + 1) void'(mq.pop_back());
            tail_slot = (int'(squash_idx) + 1) % DEPTH;
        end
        repeat (k) void'(mq.pop_front());
        n_ret += k;
        if (acc) begin
            for (int i = 0; i < n; i++) begin
                e.slot = tail_slot;
                e.arch = disp_arch[i];
                e.phys = disp_phys[i];
                e.old  = disp_old_phys[i];
                e.dest = disp_has_dest[i];
                e.done = 1'b0;
                mq.push_back(e);
                tail_slot = (tail_slot + 1) % DEPTH;
            end
            n_disp += n;
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (mq.size() > 0 && c < 300) begin
            clear_in();
            cmpl_oldest();
            step();
            c++;
        end
        clear_in();
        #1;
        check_val("drain_empty", empty, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        clear_in();
        model_clear();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int c;
        n_total = 0;
        n_bad   = 0;
        n_disp  = 0;
        n_ret   = 0;
        clear_in();
        model_clear();
        reset = 1'b0;
        @(negedge clock);
        #1;
        check_val("rst_free", free_slots, 32);
        check_val("rst_empty", empty, 1);
        check_val("rst_ret", ret_valid, 0);
        check_val("rst_accept", disp_accept, 1);
        @(negedge clock);
        reset = 1'b1;

        // Two-lane dispatch with known tags.
        disp_valid = 2'b11;
        disp_arch[0] = 5'd1;  disp_arch[1] = 5'd2;
        disp_phys[0] = 6'd33; disp_phys[1] = 6'd34;
        disp_old_phys[0] = 6'd3; disp_old_phys[1] = 6'd5;
        disp_has_dest = 2'b11;
        #1;
        check_val("t1_idx0", disp_idx[0], 0);
        check_val("t1_idx1", disp_idx[1], 1);
        step();
        clear_in();
        #1;
        check_val("t1_free", free_slots, 30);
        check_val("t1_empty", empty, 0);
        check_val("t1_ret", ret_valid, 0);

        // Out-of-order completion, in-order retire.
        cmpl_valid[0] = 1'b1; cmpl_idx[0] = 5'd1;
        step();
        clear_in();
        cmpl_valid[0] = 1'b1; cmpl_idx[0] = 5'd0;
        #1;
        check_val("t2_ret_blocked", ret_valid, 0);
        step();
        clear_in();
        #1;
        check_val("t2_ret", ret_valid, 2'b11);
        check_val("t2_phys", {ret_phys[1], ret_phys[0]}, {6'd34, 6'd33});
        check_val("t2_old", {ret_old_phys[1], ret_old_phys[0]}, {6'd5, 6'd3});
        step();
        #1;
        check_val("t2_free", free_slots, 32);

        // Fill to 31, reject a 2-group, accept a 1-group.
        c = 0;
        while (mq.size() < 31 && c < 40) begin
            set_disp((31 - mq.size() >= 2) ? 2 : 1);
            step();
            c++;
        end
        set_disp(2);
        #1;
        check_val("t3_reject", disp_accept, 0);
        step();
        clear_in();
        #1;
        check_val("t3_free1", free_slots, 1);
        set_disp(1);
        step();
        clear_in();
        #1;
        check_val("t3_full", free_slots, 0);
        drain();

        // Wrap-around: 40 entries through 2-wide.
        base = n_ret;
        n_disp = 0;
        c = 0;
        while ((n_disp < 40 || mq.size() > 0) && c < 200) begin
            clear_in();
            if (n_disp < 40) set_disp(2);
            cmpl_oldest();
            step();
            c++;
        end
        clear_in();
        check_val("t4_retired", n_ret - base, 40);

        // Squash of entries younger than slot 2.
        pulse_reset();
        repeat (3) begin
            set_disp(2);
            step();
        end
        clear_in();
        squash_valid = 1'b1;
        squash_idx   = 5'd2;
        set_disp(2);
        #1;
        check_val("t5_accept", disp_accept, 0);
        step();
        clear_in();
        #1;
        check_val("t5_free", free_slots, 29);
        cmpl_valid[0] = 1'b1; cmpl_idx[0] = 5'd4;
        step();
        clear_in();
        set_disp(1);
        #1;
        check_val("t5_reuse", disp_idx[0], 3);
        step();
        drain();

        // Asynchronous reset with 10 entries live.
        repeat (5) begin
            set_disp(2);
            step();
        end
        clear_in();
        reset = 1'b0;
        #1;
        check_val("t6_ret", ret_valid, 0);
        check_val("t6_empty", empty, 1);
        check_val("t6_free", free_slots, 32);
        model_clear();
        @(negedge clock);
        reset = 1'b1;

        // Randomised traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clear_in();
            set_disp($urandom_range(0, 2));
            for (int l = 0; l < CW; l++) begin
                if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
                    cmpl_valid[l] = 1'b1;
                    cmpl_idx[l]   = IW'(mq[$urandom_range(0, mq.size() - 1)].slot);
                end else if ($urandom_range(0, 9) == 0) begin
                    cmpl_valid[l] = 1'b1;
                    cmpl_idx[l]   = IW'($urandom);
                end
            end
            if (mq.size() > 0 && $urandom_range(0, 29) == 0) begin
                squash_valid = 1'b1;
                squash_idx   = IW'(mq[$urandom_range(0, mq.size() - 1)].slot);
            end
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised N-wide reorder buffer; successor to the single-issue ROB between stage_id (dispatch), stage_ic (complete) and stage_ir (retire).
- Adds multi-lane dispatch/complete/retire and branch-mispredict squash of younger entries.
- Retire lanes feed stage_ir, free list and map table unchanged, one lane per port slot.

Parameters:
DEPTH, 32, entries; power of two, >= 4
DISPATCH_W, 2, dispatch lanes per cycle
COMPLETE_W, 2, completion (CDB) lanes per cycle
RETIRE_W, 2, retire lanes per cycle
PHYS_W, 6, physical register tag width
ARCH_W, 5, architectural register index width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
disp_valid  in  DISPATCH_W  per-lane dispatch request; lanes contiguous from lane 0
disp_arch  in  DISPATCH_W x ARCH_W  destination arch reg
disp_phys  in  DISPATCH_W x PHYS_W  newly allocated tag T
disp_old_phys  in  DISPATCH_W x PHYS_W  previous mapping Told
disp_has_dest  in  DISPATCH_W  instruction writes a register
disp_accept  out  1  whole dispatch group accepted this cycle
disp_idx  out  DISPATCH_W x log2(DEPTH)  ROB slot assigned per lane
free_slots  out  log2(DEPTH)+1  empty entries (registered-state view)
cmpl_valid  in  COMPLETE_W  completion strobe
cmpl_idx  in  COMPLETE_W x log2(DEPTH)  completing ROB slot
squash_valid  in  1  mispredict recovery
squash_idx  in  log2(DEPTH)  mispredicted branch slot; it survives, all younger die
ret_valid  out  RETIRE_W  lane retires this cycle; contiguous from lane 0
ret_arch / ret_phys / ret_old_phys / ret_has_dest  out  per lane  retiring entry fields
empty  out  1  count == 0

Behaviour:
- State: head/tail pointers with extra wrap bit (log2(DEPTH)+1 bits); count = tail - head; per entry valid, complete, arch, phys, old_phys, has_dest.
- Reset (reset low, async): head = tail = 0, all valid/complete cleared. Outputs: ret_valid 0, free_slots DEPTH, empty 1, disp_accept 1 when disp_valid = 0.
- Dispatch: n = popcount(disp_valid). disp_accept = (n <= free_slots) && !squash_valid, combinational. All-or-nothing. Lane i writes slot tail+i at clock edge, complete = 0. disp_idx[i] = tail+i (combinational), valid even if not accepted. Non-contiguous disp_valid is illegal (bench assertion).
- free_slots ignores same-cycle retires; a full ROB retiring k entries still rejects dispatch that cycle.
- Complete: at edge, sets complete on each cmpl_idx whose entry is valid; invalid/squashed slots ignored silently. Duplicate indices across lanes are harmless. A completion is visible to retire the next cycle (1-cycle min complete->retire).
- Retire: combinational from registered state. Lane j valid iff entries head..head+j all valid && complete. Stops at the first incomplete entry, at count, or at RETIRE_W. At edge head += retired count; entries invalidated.
- Squash: at edge, tail <- squash_idx+1 (wrap bits chosen so squash_idx is within [head,tail)). Entries after squash_idx invalidated; same-cycle dispatch rejected; same-cycle completions to killed slots dropped. Same-cycle retire proceeds normally, including squash_idx itself; head/tail stay consistent (count may reach 0).
- squash_idx outside the occupied range is illegal (assertion).
- Wrap-around: all slot arithmetic is modulo DEPTH; full = count == DEPTH; empty = count == 0.

Decomposition:
- sys_defs.svh gains ROB_IDX_W, ROB_DEPTH, ROB_ENTRY typedef (valid, complete, arch, phys, old_phys, has_dest), and ROB_DISP_LANE / ROB_RET_LANE packed structs.
- One sub-module is natural: rob_retire_sel, a combinational prefix scan producing ret_valid and the retire count from head-relative complete bits.
- Popcount and pointer math stay inline.

Test Plan:
- Reset then dispatch 2 lanes (T=33,34; Told=3,5) -> disp_idx 0,1, free_slots 30, empty 0; no ret_valid.
- Complete idx1 then idx0 next cycle -> ret_valid 00 until the cycle after idx0 completes, then 11 with ret_phys 33,34, ret_old_phys 3,5; free_slots back to 32.
- Fill to 31 entries, dispatch 2 -> disp_accept 0, state unchanged; dispatch 1 -> accepted, free_slots 0.
- Wrap: cycle 40 entries through with 2-wide dispatch/retire -> disp_idx wraps 31->0, retire order preserved, no loss.
- Dispatch idx0..5, squash_valid with squash_idx 2 plus dispatch attempt -> disp_accept 0; next cycle free_slots 29; completion to idx4 ignored; idx3 reused by next dispatch.
- Assert reset low mid-stream with 10 entries -> immediately ret_valid 0, empty 1, free_slots 32.
